sa_pe_gen2: RTL

SA_PE_GEN2 -- requirements
Module: sa_pe_gen2

---
 rtl/sa_pe_pkg.sv | 52 +++++
 rtl/sa_pe_mul.sv | 37 +++
 rtl/sa_pe_gen2.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sa_pe_pkg.sv
// sa_pe_pkg: dataflow mode and FSM state enums plus the saturating adder
// used by sa_pe_gen2 when SA_PE_SAT_EN is defined.
package sa_pe_pkg;

  typedef enum logic { PE_OS = 1'b0, PE_WS = 1'b1 } pe_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } pe_state_e;

  localparam int unsigned SAT_W_MAX = 128;

  typedef struct packed {
    logic                 ovf;
    logic [SAT_W_MAX-1:0] sum;
  } sat_res_t;

  // Operands carry a right-aligned w-bit value; on overflow the sum clamps.
  function automatic sat_res_t sat_add(
    input logic [SAT_W_MAX-1:0] a,
    input logic [SAT_W_MAX-1:0] b,
    input int unsigned          w,
    input logic                 sgn
  );
    logic [SAT_W_MAX:0]   full;
    logic [SAT_W_MAX-1:0] mask;
    logic [SAT_W_MAX-1:0] sum;
    logic                 sa, sb, sr;
    sat_res_t             res;
    mask = (SAT_W_MAX'(1) << w) - SAT_W_MAX'(1);
    full = {1'b0, a} + {1'b0, b};
    sum  = full[SAT_W_MAX-1:0] & mask;
    sa   = (a >> (w - 1)) != '0;
    sb   = (b >> (w - 1)) != '0;
    sr   = (sum >> (w - 1)) != '0;
    res.ovf = 1'b0;
    res.sum = sum;
    if (sgn) begin
      if ((sa == sb) && (sr != sa)) begin
        res.ovf = 1'b1;
        res.sum = sa ? (mask >> 1) + SAT_W_MAX'(1) : (mask >> 1);
      end
    end else if ((full >> w) != '0) begin
      res.ovf = 1'b1;
      res.sum = mask;
    end
    return res;
  endfunction

endpackage

// File: rtl/sa_pe_mul.sv
// sa_pe_mul: registered DATA_W x DATA_W multiplier (signed or unsigned),
// full 2*DATA_W product; holds the last product when not enabled.
module sa_pe_mul #(
  parameter int DATA_W = 19
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic                signed_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  output logic [2*DATA_W-1:0] prod_o,
  output logic                vld_o
);

  logic [2*DATA_W-1:0] a_ext, b_ext, prod_d, prod_q;
  logic                vld_q;

  // Low 2*DATA_W bits of the extended product are exact for both signednesses.
  assign a_ext  = signed_i ? {{DATA_W{a_i[DATA_W-1]}}, a_i} : {{DATA_W{1'b0}}, a_i};
  assign b_ext  = signed_i ? {{DATA_W{b_i[DATA_W-1]}}, b_i} : {{DATA_W{1'b0}}, b_i};
  assign prod_d = en_i ? a_ext * b_ext : prod_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      prod_q <= prod_d;
      vld_q  <= en_i;
    end
  end

  assign prod_o = prod_q;
  assign vld_o  = vld_q;

endmodule

// File: rtl/sa_pe_gen2.sv
// sa_pe_gen2: systolic-array PE with output-/weight-stationary dataflow.
// Define SA_PE_SAT_EN for saturating accumulation with sticky ovf; default wraps.
module sa_pe_gen2
  import sa_pe_pkg::*;
#(
  parameter int DATA_W = 19,
  parameter int ACC_W  = 2*DATA_W + 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_mode,
  input  logic              cfg_signed,
  input  logic [DATA_W-1:0] act_in,
  input  logic              act_in_vld,
  output logic [DATA_W-1:0] act_out,
  output logic              act_out_vld,
  input  logic [DATA_W-1:0] w_in,
  input  logic              w_in_vld,
  output logic [DATA_W-1:0] w_out,
  output logic              w_out_vld,
  input  logic              w_swap,
  input  logic [ACC_W-1:0]  psum_in,
  output logic [ACC_W-1:0]  psum_out,
  output logic              psum_out_vld,
  input  logic              drain,
  input  logic              acc_clr,
  output logic              busy,
  output logic              ovf
);

  // state | meaning
  // IDLE  | nothing in flight; cfg follows the cfg_* inputs
  // RUN   | activations/products in flight; cfg frozen
  // DRAIN | OS shift-out, psum_out <= psum_in each cycle

  pe_state_e             state_q, state_d;
  pe_mode_e              mode_q, mode_eff;
  logic                  signed_q, signed_eff;
  logic [DATA_W-1:0]     act_out_q, w_out_q, w_out_d, shadow_q, shadow_d, w_act_q, w_act_d;
  logic                  act_vld_q, w_vld_q;
  logic [ACC_W-1:0]      psum_q, psum_d, prod_ext, add_base, add_sum;
  logic                  psum_vld_q, psum_vld_d, ovf_q, ovf_d, add_ovf;
  logic [DATA_W-1:0]     w_sel;
  logic                  mul_en, prod_vld;
  logic [2*DATA_W-1:0]   prod_r;

  assign mode_eff   = (state_q == ST_IDLE) ? pe_mode_e'(cfg_mode) : mode_q;
  assign signed_eff = (state_q == ST_IDLE) ? cfg_signed : signed_q;
  assign mul_en     = act_in_vld && (state_q != ST_DRAIN);
  assign w_sel      = (mode_eff == PE_WS) ? w_act_q : w_in;

  sa_pe_mul #(.DATA_W(DATA_W)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (mul_en),
    .signed_i (signed_eff),
    .a_i      (act_in),
    .b_i      (w_sel),
    .prod_o   (prod_r),
    .vld_o    (prod_vld)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (drain && mode_eff == PE_OS) state_d = ST_DRAIN;
                else if (act_in_vld)            state_d = ST_RUN;
      ST_RUN:   if (drain && mode_eff == PE_OS) state_d = ST_DRAIN;
                else if (!act_in_vld && !prod_vld) state_d = ST_IDLE;
      ST_DRAIN: if (!drain)                     state_d = ST_IDLE;
      default:                                  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    w_out_d  = w_out_q;
    shadow_d = shadow_q;
    w_act_d  = w_act_q;
    if (mode_eff == PE_OS) begin
      w_out_d = w_in;
    end else begin
      if (w_in_vld) begin
        shadow_d = w_in;
        w_out_d  = shadow_q;
      end
      if (w_swap) w_act_d = shadow_q;
    end
  end

  always_comb begin
    prod_ext = ACC_W'(prod_r);
    if (signed_eff && prod_r[2*DATA_W-1]) prod_ext = prod_ext | ~ACC_W'({(2*DATA_W){1'b1}});
  end

  assign add_base = (mode_eff == PE_WS) ? psum_in : psum_q;

`ifdef SA_PE_SAT_EN
  sat_res_t sat_res;
  assign sat_res = sat_add(SAT_W_MAX'(add_base), SAT_W_MAX'(prod_ext), ACC_W, signed_eff);
  assign add_sum = sat_res.sum[ACC_W-1:0];
  assign add_ovf = sat_res.ovf;
`else
  assign add_sum = add_base + prod_ext;
  assign add_ovf = 1'b0;
`endif

  always_comb begin
    psum_d     = psum_q;
    psum_vld_d = 1'b0;
    ovf_d      = ovf_q;
    if (acc_clr) begin
      psum_d = '0;
      ovf_d  = 1'b0;
    end else if (state_q == ST_DRAIN) begin
      psum_d     = psum_in;
      psum_vld_d = 1'b1;
    end else if (prod_vld) begin
      psum_d     = add_sum;
      ovf_d      = ovf_q | add_ovf;
      psum_vld_d = (mode_eff == PE_WS);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= PE_OS;
      signed_q   <= 1'b0;
      act_out_q  <= '0;
      act_vld_q  <= 1'b0;
      w_out_q    <= '0;
      w_vld_q    <= 1'b0;
      shadow_q   <= '0;
      w_act_q    <= '0;
      psum_q     <= '0;
      psum_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) begin
        mode_q   <= mode_eff;
        signed_q <= signed_eff;
      end
      act_out_q  <= act_in;
      act_vld_q  <= mul_en;
      w_out_q    <= w_out_d;
      w_vld_q    <= w_in_vld;
      shadow_q   <= shadow_d;
      w_act_q    <= w_act_d;
      psum_q     <= psum_d;
      psum_vld_q <= psum_vld_d;
      ovf_q      <= ovf_d;
    end
  end

  assign act_out      = act_out_q;
  assign act_out_vld  = act_vld_q;
  assign w_out        = w_out_q;
  assign w_out_vld    = w_vld_q;
  assign psum_out     = psum_q;
  assign psum_out_vld = psum_vld_q;
  assign busy         = (state_q != ST_IDLE);
  assign ovf          = ovf_q;

endmodule
